execute_block: RTL
==================

EXECUTE_BLOCK -- requirements
Module: execute_block

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous, active-low.
REQ-002 SHALL have op_a in 16, ALU operand A; op_b in 16, ALU operand B / shift amount.
REQ-003 SHALL have alu_op in 4, operation select; valid_rr in 1, instruction present from register-read stage.
REQ-004 SHALL have store_data_rr in 16, store data; mem_rw_rr, mem_en_rr, mem_mux_sel_rr in 1 each, memory controls from register-read stage.
REQ-005 SHALL have ans_ex out 16, registered result and memory address; DM_data out 16, registered store data.
REQ-006 SHALL have mem_rw_ex, mem_en_ex, mem_mux_sel_dm out 1 each, registered memory controls to the data memory stage.
REQ-007 SHALL have z_ex out 1, registered zero flag; c_ex out 1, registered carry flag; stall_ex out 1, combinational hold request to upstream stages.

Function
REQ-008 alu_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SLL A by op_b[3:0], 7 SRL, 8 SRA, 9 MUL (low 16 bits), 10 pass B; 11-15 pass A.
REQ-009 Non-MUL op with valid_rr=1 and stall_ex=0: result, store_data_rr and controls registered at next edge (1-cycle latency).
REQ-010 ADD: c_ex = carry out of bit 15; SUB: A + ~B + 1, c_ex = 1 when A >= B unsigned; all other ops c_ex = 0.
REQ-011 z_ex = 1 when registered 16-bit result is 0x0000, for every op including MUL.
REQ-012 valid_rr=0 (not stalled): bubble -- mem_en_ex=0, mem_rw_ex=0, mem_mux_sel_dm=0; ans_ex, DM_data, z_ex, c_ex hold.
REQ-013 MUL FSM states IDLE, BUSY, DONE; IDLE -> BUSY at an edge where valid_rr=1 and alu_op=9, capturing op_a, op_b, clearing accumulator and 4-bit counter.
REQ-014 BUSY: one shift-add iteration per edge (multiplier LSB first, accumulator 16-bit, overflow discarded); after 16 iterations -> DONE.
REQ-015 DONE: at next edge product written to ans_ex, flags, captured controls to outputs; -> IDLE; no restart on that edge.
REQ-016 stall_ex = (IDLE and valid_rr and alu_op=9) or BUSY; high exactly 17 cycles per MUL; product on ans_ex after 18th edge from presentation.
REQ-017 While stall_ex=1, outputs SHALL issue bubbles per REQ-012; upstream SHALL hold inputs stable (alu_op change during BUSY ignored).
REQ-018 Back-to-back MUL: second MUL accepted in cycle after DONE edge (IDLE), with its own 17-cycle stall.
REQ-019 MUL store_data and memory controls SHALL be those captured at IDLE -> BUSY edge.

Reset
REQ-020 reset=0 at an edge: ans_ex=0, DM_data=0, mem_rw_ex=0, mem_en_ex=0, mem_mux_sel_dm=0, z_ex=0, c_ex=0, FSM IDLE, counter 0.
REQ-021 reset during BUSY/DONE SHALL abort MUL with no result written; stall_ex follows REQ-016 from IDLE state.
REQ-022 reset SHALL take priority over all other events at the same edge.

Configuration
REQ-023 Macro EXECUTE_MUL_EN defined: iterative multiplier and FSM per REQ-013..REQ-019 compiled in.
REQ-024 EXECUTE_MUL_EN undefined: no FSM; alu_op=9 single-cycle result 0x0000, z_ex=1, c_ex=0; stall_ex tied 0.

Verification
REQ-025 ADD 0xFFFF + 0x0001, valid_rr=1 -> next edge ans_ex=0x0000, z_ex=1, c_ex=1.
REQ-026 SUB 0x0005 - 0x0007 -> ans_ex=0xFFFE, c_ex=0, z_ex=0; SRA 0x8000 by 3 -> 0xF000.
REQ-027 MUL 0x0123 x 0x0045 (EXECUTE_MUL_EN) -> stall_ex high 17 cycles, mem_en_ex=0 meanwhile, ans_ex=0x4E6F after 18th edge.
REQ-028 Store op ADD 0x0010+0x0004, store_data_rr=0xBEEF, mem_en_rr=1, mem_rw_rr=1 -> ans_ex=0x0014, DM_data=0xBEEF, mem_en_ex=1, mem_rw_ex=1.
REQ-029 reset=0 in 8th BUSY cycle of MUL -> all outputs 0, stall_ex=0 next cycle with valid_rr=0; later ADD completes in 1 cycle.
REQ-030 Build without EXECUTE_MUL_EN, MUL 0x0003 x 0x0004 -> stall_ex never high, ans_ex=0x0000, z_ex=1 next edge.

Source files
------------

// File: rtl/execute_if.sv
// Execute-stage bundle: register-read stage inputs and the registered
// results/controls handed on to the data-memory stage.
interface execute_if;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  alu_op;
    logic        valid_rr;
    logic [15:0] store_data_rr;
    logic        mem_rw_rr;
    logic        mem_en_rr;
    logic        mem_mux_sel_rr;
    logic [15:0] ans_ex;
    logic [15:0] DM_data;
    logic        mem_rw_ex;
    logic        mem_en_ex;
    logic        mem_mux_sel_dm;
    logic        z_ex;
    logic        c_ex;
    logic        stall_ex;

    modport master (
        output op_a, op_b, alu_op, valid_rr, store_data_rr,
               mem_rw_rr, mem_en_rr, mem_mux_sel_rr,
        input  ans_ex, DM_data, mem_rw_ex, mem_en_ex, mem_mux_sel_dm,
               z_ex, c_ex, stall_ex
    );

    modport slave (
        input  op_a, op_b, alu_op, valid_rr, store_data_rr,
               mem_rw_rr, mem_en_rr, mem_mux_sel_rr,
        output ans_ex, DM_data, mem_rw_ex, mem_en_ex, mem_mux_sel_dm,
               z_ex, c_ex, stall_ex
    );
endinterface

// File: rtl/execute_block.sv
// Execute stage: single-cycle ALU with registered result, flags and memory
// controls; optional 16-cycle shift-add multiplier enabled by EXECUTE_MUL_EN.
module execute_block (
    input  logic     clk,
    input  logic     reset,
    execute_if.slave bus
);
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;

    logic [16:0] w_add;
    logic [16:0] w_sub;
    logic [15:0] w_alu_res;
    logic        w_alu_c;
    logic        w_stall;
    logic        w_mul_done;
    logic [15:0] w_mul_res;
    logic [15:0] w_mul_dm;
    logic        w_mul_rw;
    logic        w_mul_en;
    logic        w_mul_mux;
    logic        w_wr_en;
    logic [15:0] w_ans_d;
    logic [15:0] w_dm_d;
    logic        w_c_d;
    logic        w_rw_d;
    logic        w_en_d;
    logic        w_mux_d;

    logic [15:0] r_ans;
    logic [15:0] r_dm;
    logic        r_rw;
    logic        r_en;
    logic        r_mux;
    logic        r_z;
    logic        r_c;

    // Carry out of SUB is the "no borrow" bit, i.e. A >= B unsigned.
    assign w_add = {1'b0, bus.op_a} + {1'b0, bus.op_b};
    assign w_sub = {1'b0, bus.op_a} + {1'b0, ~bus.op_b} + 17'd1;

    // Single-cycle ALU result and carry
    always_comb begin
        w_alu_res = bus.op_a;
        w_alu_c   = 1'b0;
        case (bus.alu_op)
            OP_ADD:   begin w_alu_res = w_add[15:0]; w_alu_c = w_add[16]; end
            OP_SUB:   begin w_alu_res = w_sub[15:0]; w_alu_c = w_sub[16]; end
            OP_AND:   w_alu_res = bus.op_a & bus.op_b;
            OP_OR:    w_alu_res = bus.op_a | bus.op_b;
            OP_XOR:   w_alu_res = bus.op_a ^ bus.op_b;
            OP_NOT:   w_alu_res = ~bus.op_a;
            OP_SLL:   w_alu_res = bus.op_a << bus.op_b[3:0];
            OP_SRL:   w_alu_res = bus.op_a >> bus.op_b[3:0];
            OP_SRA:   w_alu_res = $signed(bus.op_a) >>> bus.op_b[3:0];
            OP_MUL:   w_alu_res = 16'h0000;
            OP_PASSB: w_alu_res = bus.op_b;
            default:  w_alu_res = bus.op_a;
        endcase
    end

`ifdef EXECUTE_MUL_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mul_state_t;

    mul_state_t  r_state;
    logic [15:0] r_mcand;
    logic [15:0] r_mplier;
    logic [15:0] r_acc;
    logic [3:0]  r_cnt;
    logic [15:0] r_mul_dm;
    logic        r_mul_rw;
    logic        r_mul_en;
    logic        r_mul_mux;
    logic        w_mul_start;

    assign w_mul_start = (r_state == S_IDLE) && bus.valid_rr && (bus.alu_op == OP_MUL);
    assign w_stall     = w_mul_start || (r_state == S_BUSY);
    assign w_mul_done  = (r_state == S_DONE);
    assign w_mul_res   = r_acc;
    assign w_mul_dm    = r_mul_dm;
    assign w_mul_rw    = r_mul_rw;
    assign w_mul_en    = r_mul_en;
    assign w_mul_mux   = r_mul_mux;

    // Multiplier sequencer: capture, 16 shift-add iterations, one result cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_mcand   <= 16'h0000;
            r_mplier  <= 16'h0000;
            r_acc     <= 16'h0000;
            r_cnt     <= 4'd0;
            r_mul_dm  <= 16'h0000;
            r_mul_rw  <= 1'b0;
            r_mul_en  <= 1'b0;
            r_mul_mux <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mul_start) begin
                        r_mcand   <= bus.op_a;
                        r_mplier  <= bus.op_b;
                        r_acc     <= 16'h0000;
                        r_cnt     <= 4'd0;
                        r_mul_dm  <= bus.store_data_rr;
                        r_mul_rw  <= bus.mem_rw_rr;
                        r_mul_en  <= bus.mem_en_rr;
                        r_mul_mux <= bus.mem_mux_sel_rr;
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign w_stall    = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_mul_res  = 16'h0000;
    assign w_mul_dm   = 16'h0000;
    assign w_mul_rw   = 1'b0;
    assign w_mul_en   = 1'b0;
    assign w_mul_mux  = 1'b0;
`endif

    // Select what the output registers load: multiplier result, ALU result, or a bubble
    always_comb begin
        w_wr_en = 1'b0;
        w_ans_d = 16'h0000;
        w_dm_d  = 16'h0000;
        w_c_d   = 1'b0;
        w_rw_d  = 1'b0;
        w_en_d  = 1'b0;
        w_mux_d = 1'b0;
        if (w_mul_done) begin
            w_wr_en = 1'b1;
            w_ans_d = w_mul_res;
            w_dm_d  = w_mul_dm;
            w_rw_d  = w_mul_rw;
            w_en_d  = w_mul_en;
            w_mux_d = w_mul_mux;
        end else if (!w_stall && bus.valid_rr) begin
            w_wr_en = 1'b1;
            w_ans_d = w_alu_res;
            w_dm_d  = bus.store_data_rr;
            w_c_d   = w_alu_c;
            w_rw_d  = bus.mem_rw_rr;
            w_en_d  = bus.mem_en_rr;
            w_mux_d = bus.mem_mux_sel_rr;
        end else begin
            w_wr_en = 1'b0;
        end
    end

    // Output registers; a bubble clears memory controls and holds data and flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ans <= 16'h0000;
            r_dm  <= 16'h0000;
            r_rw  <= 1'b0;
            r_en  <= 1'b0;
            r_mux <= 1'b0;
            r_z   <= 1'b0;
            r_c   <= 1'b0;
        end else if (w_wr_en) begin
            r_ans <= w_ans_d;
            r_dm  <= w_dm_d;
            r_rw  <= w_rw_d;
            r_en  <= w_en_d;
            r_mux <= w_mux_d;
            r_z   <= (w_ans_d == 16'h0000);
            r_c   <= w_c_d;
        end else begin
            r_rw  <= 1'b0;
            r_en  <= 1'b0;
            r_mux <= 1'b0;
        end
    end

    assign bus.ans_ex         = r_ans;
    assign bus.DM_data        = r_dm;
    assign bus.mem_rw_ex      = r_rw;
    assign bus.mem_en_ex      = r_en;
    assign bus.mem_mux_sel_dm = r_mux;
    assign bus.z_ex           = r_z;
    assign bus.c_ex           = r_c;
    assign bus.stall_ex       = w_stall;
endmodule
